// File: rtl/alu_regfile_seq.sv
// rtl/alu_regfile_seq.sv - multi-cycle ALU over a register file with start/busy/done handshake
// External load port, combinational debug read and LED byte mux of the result.
module alu_regfile_seq #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  output logic              busy,
  output logic              done,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]  ext_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  F,
  output logic              ZF,
  output logic              OF,
  output logic              CF,
  input  logic [2:0]        SW,
  output logic [7:0]        LED
);
  localparam int NREG = 2**ADDR_W;
  localparam int SH_W = $clog2(WIDTH);
  localparam int PW   = (WIDTH < 64) ? 64 : WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]        state;
  logic [WIDTH-1:0]  regs [NREG];
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [WIDTH-1:0]  rdata_a, rdata_b;
  logic [WIDTH-1:0]  alu_f;
  logic              alu_of, alu_cf;
  logic [WIDTH:0]    sum, diff;
  logic [PW-1:0]     f_pad;

  assign busy     = (state != S_IDLE);
  assign rdata_a  = (R0_ZERO && rs1_q == '0) ? '0 : regs[rs1_q];
  assign rdata_b  = (R0_ZERO && rs2_q == '0) ? '0 : regs[rs2_q];
  assign dbg_data = (R0_ZERO && dbg_addr == '0) ? '0 : regs[dbg_addr];

  // Zero-padded to 64 bits so byte lanes beyond WIDTH read as 0.
  assign f_pad = PW'(F);
  assign LED   = f_pad[{SW, 3'b000} +: 8];

  always_comb begin
    sum    = {1'b0, A} + {1'b0, B};
    diff   = {1'b0, A} - {1'b0, B};
    alu_f  = '0;
    alu_of = 1'b0;
    alu_cf = 1'b0;
    case (op_q)
      3'b000: alu_f = A & B;
      3'b001: alu_f = A | B;
      3'b010: alu_f = A ^ B;
      3'b011: alu_f = ~(A | B);
      3'b100: begin
        alu_f  = sum[WIDTH-1:0];
        alu_cf = sum[WIDTH];
        alu_of = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b101: begin
        alu_f  = diff[WIDTH-1:0];
        alu_cf = diff[WIDTH];
        alu_of = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      3'b110: alu_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_f = A << B[SH_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      A     <= '0;
      B     <= '0;
      F     <= '0;
      ZF    <= 1'b1;
      OF    <= 1'b0;
      CF    <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The read happens an edge later, so a same-edge ext write is seen.
          if (ext_we && !(R0_ZERO && ext_addr == '0)) regs[ext_addr] <= ext_data;
          if (start) begin
            op_q  <= op;
            rs1_q <= rs1;
            rs2_q <= rs2;
            rd_q  <= rd;
            state <= S_READ;
          end
        end
        S_READ: begin
          A     <= rdata_a;
          B     <= rdata_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          F     <= alu_f;
          ZF    <= (alu_f == '0);
          OF    <= alu_of;
          CF    <= alu_cf;
          state <= S_WB;
        end
        default: begin
          if (!(R0_ZERO && rd_q == '0)) regs[rd_q] <= F;
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Parametrised successor to the lab-8 single-cycle ALU + register-file top.
- Multi-cycle datapath:
  - register file with two read ports and one write port;
  - 8-op ALU with ZF/OF/CF flags;
  - start/busy/done handshake;
  - external load port and LED byte-display mux.
- Sits under the board-level top. Switches and LEDs drive it; the testbench drives it directly.

Parameters:
- WIDTH, 32, datapath and register width; multiple of 8, minimum 8.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- R0_ZERO, 1, when 1 register 0 reads as 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  3  ALU opcode.
- rs1  in  ADDR_W  source register for operand A.
- rs2  in  ADDR_W  source register for operand B.
- rd  in  ADDR_W  destination register.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when write-back occurs.
- ext_we  in  1  external register write enable.
- ext_addr  in  ADDR_W  external write address.
- ext_data  in  WIDTH  external write data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  WIDTH  combinational read of reg[dbg_addr].
- A  out  WIDTH  latched operand A.
- B  out  WIDTH  latched operand B.
- F  out  WIDTH  latched ALU result.
- ZF  out  1  zero flag.
- OF  out  1  signed overflow flag.
- CF  out  1  carry/borrow flag.
- SW  in  3  LED byte select.
- LED  out  8  selected byte of F.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; A, B, F = 0; ZF = 1; OF, CF, done, busy = 0.
  - All registers cleared to 0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - Start is accepted at edge k: IDLE with start=1 moves to READ and captures op/rs1/rs2/rd internally.
  - Edge k+1: A = reg[rs1], B = reg[rs2]; go to EXEC.
  - Edge k+2: F and flags latched; go to WB.
  - Edge k+3: reg[rd] = F (unless rd=0 and R0_ZERO=1); done=1 for this cycle only; go to IDLE.
  - Latency from start sample to done is 3 cycles; throughput is one op per 4 cycles.
- Handshake rules:
  - start while busy is ignored; captured fields do not change mid-operation.
  - start high in the cycle done is high is accepted, because the state is IDLE in that cycle.
- ALU ops (WIDTH-bit, two's complement):
  - 000 AND; 001 OR; 010 XOR; 011 NOR.
  - 100 ADD: CF = carry out; OF = signed overflow.
  - 101 SUB (A-B): CF = borrow (A<B unsigned); OF = signed overflow.
  - 110 SLT: F = 1 if A<B signed, else 0.
  - 111 SLL: A << B[log2(WIDTH)-1:0].
- Flags:
  - OF and CF are 0 for all ops except ADD/SUB.
  - ZF = (F==0), updated every EXEC.
- External write port:
  - ext_we is honoured only in IDLE and writes at the clock edge; it is ignored while busy.
  - If start and ext_we are both high in IDLE: the ext write completes at that edge and start is also accepted. READ happens one edge later, so it sees the new value.
- Reads:
  - dbg_data is combinational and reflects writes from the following cycle onward.
  - With R0_ZERO=1, address 0 always reads 0.
- LED mux:
  - LED = F[8*SW+7 : 8*SW] when 8*SW < WIDTH, else 8'h00. Combinational from F.
- Reset mid-operation:
  - Immediate return to IDLE with all state cleared.
  - No partial write occurs and no done pulse is produced.

Test Plan:
- Reset, then ext-load reg1=32'h7FFF_FFFF, reg2=32'h0000_0001. Start op=100 rs1=1 rs2=2 rd=3 -> done exactly 3 cycles after start; F=32'h8000_0000, OF=1, CF=0, ZF=0; dbg_data(3)=32'h8000_0000; LED with SW=3 = 8'h80.
- reg4=5, reg5=5. Op=101 rs1=4 rs2=5 rd=6 -> F=0, ZF=1, CF=0. Then op=101 rs1=0 rs2=4 -> F=32'hFFFF_FFFB, CF=1, OF=0.
- Op=110 with A=32'hFFFF_FFFF, B=1 -> F=1. Op=111 with A=1, B=35 -> F=8 (shift amount masked to 5 bits).
- Hold start=1 continuously: one done every 4 cycles; pulses on start held during busy are not doubled. Write rd=0 -> dbg_data(0) stays 0.
- Assert ext_we during EXEC -> the target register is unchanged.
- Drop rst during WB -> done never pulses, the destination register = 0, and all outputs return to their reset values immediately.
